// File: rtl/verinject_injection_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Package   : verinject_pkg
// Purpose   : Shared bus codes and the event record used by the verinject
//             injection scheduler and its event FIFO.
// Contents  : VERINJECT_STATE_IDLE  - bus value when nothing is injected
//             VERINJECT_STATE_CLEAR - bus value that clears FIFO injectors
//             verinject_event_t     - {clear, cycle, index} event record
// Revision  : 1.0 - initial release
// ============================================================================
package verinject_pkg;

    localparam logic [31:0] VERINJECT_STATE_IDLE  = 32'hFFFF_FFFF;
    localparam logic [31:0] VERINJECT_STATE_CLEAR = 32'hFFFF_FFFE;

    typedef struct packed {
        logic        clear;
        logic [31:0] cycle;
        logic [31:0] index;
    } verinject_event_t;

endpackage : verinject_pkg
`default_nettype wire

// File: rtl/verinject_injection_scheduler_if.sv
`default_nettype none
// ============================================================================
// Interface : verinject_injection_scheduler_if
// Purpose   : Valid/ready event offer channel into the injection scheduler.
// Signals   : ev_valid - event offer         (master -> slave)
//             ev_ready - event accept        (slave  -> master)
//             ev_cycle - target cycle number (master -> slave)
//             ev_index - bit index to inject (master -> slave)
//             ev_clear - emit clear code     (master -> slave)
// Revision  : 1.0 - initial release
// ============================================================================
interface verinject_injection_scheduler_if;

    logic        ev_valid;
    logic        ev_ready;
    logic [31:0] ev_cycle;
    logic [31:0] ev_index;
    logic        ev_clear;

    modport master (
        output ev_valid,
        output ev_cycle,
        output ev_index,
        output ev_clear,
        input  ev_ready
    );

    modport slave (
        input  ev_valid,
        input  ev_cycle,
        input  ev_index,
        input  ev_clear,
        output ev_ready
    );

endinterface : verinject_injection_scheduler_if
`default_nettype wire

// File: rtl/verinject_injection_scheduler_event_fifo.sv
`default_nettype none
// ============================================================================
// Module    : verinject_event_fifo
// Purpose   : Synchronous FIFO of verinject_event_t with wrap-around
//             pointers and an occupancy count. Head is combinational from
//             the storage array (first-word fall-through).
// Ports     : clk, rst      - clock, synchronous active-high reset
//             i_push        - write i_push_data (ignored when full)
//             i_push_data   - event to enqueue
//             i_pop         - drop the head entry (ignored when empty)
//             o_head        - oldest entry
//             o_full        - count == DEPTH
//             o_empty       - count == 0
//             o_count       - occupancy
// Revision  : 1.0 - initial release
// ============================================================================
module verinject_event_fifo
    import verinject_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int DEPTH_LOG2 = 2
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    input  wire logic                  i_push,
    input  wire verinject_event_t      i_push_data,
    input  wire logic                  i_pop,
    output verinject_event_t           o_head,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [DEPTH_LOG2:0]        o_count
);

    localparam logic [DEPTH_LOG2:0] C_DEPTH = (DEPTH_LOG2 + 1)'(DEPTH);

    verinject_event_t        r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0]   r_wr_ptr;
    logic [DEPTH_LOG2-1:0]   r_rd_ptr;
    logic [DEPTH_LOG2:0]     r_count;

    logic w_do_push;
    logic w_do_pop;

    assign o_full    = (r_count == C_DEPTH);
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rd_ptr];

    // No bypass when full: a push is refused even if a pop happens this cycle.
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop  & ~o_empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset; stale entries are never visible while empty.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_push_data;
    end

endmodule : verinject_event_fifo
`default_nettype wire

// File: rtl/verinject_injection_scheduler.sv
`default_nettype none
// ============================================================================
// Module    : verinject_injection_scheduler
// Purpose   : Time-ordered fault-injection event source. Buffers
//             (cycle, index) events and drives each index, or the clear
//             code, on the injector state bus for exactly one clock at the
//             scheduled cycle. Late events are dropped and counted.
// Ports     : clock, reset               - clock, sync active-high reset
//             enable                     - counter advance / emission enable
//             ev                         - event offer channel (slave)
//             verinject__injector_state  - registered injector state bus
//             cycle_count                - free-running cycle counter
//             pending                    - FIFO occupancy
//             missed_count               - late events dropped, saturating
// Revision  : 1.0 - initial release
// ============================================================================
module verinject_injection_scheduler
    import verinject_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int DEPTH_LOG2 = 2
) (
    input  wire logic                   clock,
    input  wire logic                   reset,
    input  wire logic                   enable,
    verinject_injection_scheduler_if.slave ev,
    output logic [31:0]                 verinject__injector_state,
    output logic [31:0]                 cycle_count,
    output logic [DEPTH_LOG2:0]         pending,
    output logic [15:0]                 missed_count
);

    logic [31:0]      r_state;
    logic [31:0]      r_cycle;
    logic [15:0]      r_missed;

    verinject_event_t w_push_data;
    verinject_event_t w_head;
    logic             w_full;
    logic             w_empty;
    logic             w_head_due;
    logic             w_head_late;
    logic             w_pop;

    assign w_push_data.clear = ev.ev_clear;
    assign w_push_data.cycle = ev.ev_cycle;
    assign w_push_data.index = ev.ev_index;

    verinject_event_fifo #(
        .DEPTH      (DEPTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk         (clock),
        .rst         (reset),
        .i_push      (ev.ev_valid),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_count     (pending)
    );

    assign ev.ev_ready = ~w_full;

    // Head is inspected only while enabled; an exactly-due head is emitted,
    // an overdue head is discarded as missed, a future head waits.
    assign w_head_due  = enable & ~w_empty & (w_head.cycle == r_cycle);
    assign w_head_late = enable & ~w_empty & (w_head.cycle <  r_cycle);
    assign w_pop       = w_head_due | w_head_late;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= VERINJECT_STATE_IDLE;
            r_cycle  <= '0;
            r_missed <= '0;
        end else begin
            if (enable) r_cycle <= r_cycle + 32'd1;

            // Bus holds a value for one cycle only, then falls back to IDLE.
            if (w_head_due)
                r_state <= w_head.clear ? VERINJECT_STATE_CLEAR : w_head.index;
            else
                r_state <= VERINJECT_STATE_IDLE;

            if (w_head_late && (r_missed != 16'hFFFF))
                r_missed <= r_missed + 16'd1;
        end
    end

    assign verinject__injector_state = r_state;
    assign cycle_count               = r_cycle;
    assign missed_count              = r_missed;

endmodule : verinject_injection_scheduler
`default_nettype wire
